// File: rtl/filtered_trace_packetizer.sv
// Aligns trace packets with their delayed filter decision, buffers kept packets
// in a FIFO and streams them out as AXI-Stream transfers closed by tlast.
module filtered_trace_packetizer #(
    parameter int AXI_DATA_WIDTH = 512,
    parameter int FILTER_LATENCY = 2,
    parameter int FIFO_DEPTH     = 16,
    parameter int FILL_WIDTH     = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [AXI_DATA_WIDTH-1:0] data_pkt,
    input  logic                      pkt_valid,
    input  logic                      keep_pkt,
    input  logic [15:0]               transfer_len,
    input  logic                      clear_stats,
    output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic [FILL_WIDTH-1:0]     fill_level,
    output logic [31:0]               dropped_count,
    output logic                      overflow,
    output logic                      busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [FILL_WIDTH-1:0] DEPTH_V = FILL_WIDTH'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_PAD
    } state_e;

    state_e state_q, state_d;

    logic [FILTER_LATENCY-1:0]                     dly_vld_q, dly_vld_d;
    logic [FILTER_LATENCY-1:0][AXI_DATA_WIDTH-1:0] dly_data_q, dly_data_d;

    logic [AXI_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [FILL_WIDTH-1:0]     wr_ptr_q, wr_ptr_d;
    logic [FILL_WIDTH-1:0]     rd_ptr_q, rd_ptr_d;
    logic [15:0]               beat_cnt_q, beat_cnt_d;
    logic [31:0]               dropped_q, dropped_d;
    logic                      overflow_q, overflow_d;

    logic [FILL_WIDTH-1:0] fill;
    logic [15:0]           len_m1;
    logic                  fifo_empty, fifo_full, fifo_one;
    logic                  kept, fire, rd_en, wr_req, wr_en, drop;

    assign fill       = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (fill == '0);
    assign fifo_full  = (fill == DEPTH_V);
    assign fifo_one   = (fill == FILL_WIDTH'(1));
    assign len_m1     = (transfer_len == 16'd0) ? 16'd0 : transfer_len - 16'd1;
    assign kept       = dly_vld_q[FILTER_LATENCY-1] && keep_pkt;

    assign fire   = m_axis_tvalid && m_axis_tready;
    assign rd_en  = fire && (state_q != ST_PAD);
    assign wr_req = kept && (state_q == ST_RUN);
    // A full FIFO still accepts the write when a pop frees the slot this cycle.
    assign wr_en  = wr_req && (!fifo_full || rd_en);
    assign drop   = wr_req && !wr_en;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (en) state_d = ST_RUN;
            ST_RUN:   if (!en) state_d = ST_DRAIN;
            ST_DRAIN: if (fifo_empty) state_d = (beat_cnt_q == 16'd0) ? ST_IDLE : ST_PAD;
            ST_PAD:   if (fire) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        m_axis_tvalid = !fifo_empty || (state_q == ST_PAD);
        m_axis_tdata  = '0;
        if (state_q != ST_PAD && !fifo_empty) begin
            m_axis_tdata = mem_q[rd_ptr_q[AW-1:0]];
        end
        // Length compare uses >= so a shortened transfer_len closes the transfer at once.
        m_axis_tlast = m_axis_tvalid && ((state_q == ST_PAD)
                                      || (state_q == ST_DRAIN && fifo_one)
                                      || (beat_cnt_q >= len_m1));
        busy = (state_q != ST_IDLE);
    end

    always_comb begin
        dly_vld_d[0]  = pkt_valid;
        dly_data_d[0] = data_pkt;
        for (int i = 1; i < FILTER_LATENCY; i++) begin
            dly_vld_d[i]  = dly_vld_q[i-1];
            dly_data_d[i] = dly_data_q[i-1];
        end

        wr_ptr_d   = wr_en ? wr_ptr_q + FILL_WIDTH'(1) : wr_ptr_q;
        rd_ptr_d   = rd_en ? rd_ptr_q + FILL_WIDTH'(1) : rd_ptr_q;
        beat_cnt_d = beat_cnt_q;
        if (fire) begin
            beat_cnt_d = m_axis_tlast ? 16'd0 : beat_cnt_q + 16'd1;
        end

        dropped_d  = dropped_q;
        overflow_d = overflow_q;
        if (clear_stats) begin
            dropped_d  = drop ? 32'd1 : 32'd0;
            overflow_d = drop;
        end else if (drop) begin
            dropped_d  = (dropped_q != '1) ? dropped_q + 32'd1 : dropped_q;
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly_vld_q  <= '0;
            dly_data_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            beat_cnt_q <= '0;
            dropped_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            dly_vld_q  <= dly_vld_d;
            dly_data_q <= dly_data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            dropped_q  <= dropped_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: storage is not reset; the pointers define which entries are valid
    // and tdata is forced to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= dly_data_q[FILTER_LATENCY-1];
        end
    end

    assign fill_level    = fill;
    assign dropped_count = dropped_q;
    assign overflow      = overflow_q;

endmodule

// File: doc/filtered_trace_packetizer.md
Name: filtered_trace_packetizer

Overview:
- Downstream consumer of the advanced trace filter.
- Aligns each trace data packet with its delayed keep/drop decision and buffers kept packets in a FIFO.
- Streams the buffered packets to the DMA engine over AXI-Stream, closing each transfer with tlast.
- Counts packets lost to overflow and cleanly terminates the open transfer when tracing is disabled.

Parameters:
- AXI_DATA_WIDTH, 512, width of one trace packet and of m_axis_tdata.
- FILTER_LATENCY, 2, cycles from pkt_valid to the matching keep_pkt at the filter output (range 1..8).
- FIFO_DEPTH, 16, number of buffered packets (power of 2).
- FILL_WIDTH, 5, width of fill_level; equals log2(FIFO_DEPTH)+1.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  tracing enable; 1->0 starts drain.
- data_pkt  in  AXI_DATA_WIDTH  trace packet presented to the filter.
- pkt_valid  in  1  data_pkt valid this cycle.
- keep_pkt  in  1  filter decision, valid FILTER_LATENCY cycles after pkt_valid.
- transfer_len  in  16  beats per AXI-Stream transfer; 0 is treated as 1.
- clear_stats  in  1  synchronous clear of dropped_count and overflow.
- m_axis_tdata  out  AXI_DATA_WIDTH  output beat.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last beat of transfer.
- fill_level  out  FILL_WIDTH  current FIFO occupancy.
- dropped_count  out  32  kept packets discarded because the FIFO was full (saturating).
- overflow  out  1  sticky; set on first drop.
- busy  out  1  high in RUN, DRAIN and PAD states.

Behaviour:
Reset:
- Async rst clears state to IDLE, the FIFO, the delay line, the beat counter, dropped_count and overflow.
- All outputs are 0 after reset.

Alignment:
- FILTER_LATENCY-deep shift register of {pkt_valid, data_pkt}.
- A delayed entry is "kept" when its delayed valid and keep_pkt are both 1 in the same cycle.
- keep_pkt while delayed valid=0 is ignored.

FIFO write:
- Write a kept entry only in state RUN.
- If the FIFO is full, discard the entry, increment dropped_count (saturating at 0xFFFFFFFF) and set overflow.
- A simultaneous read and write when full is allowed: the write is accepted with no drop.
- Kept entries arriving in IDLE, DRAIN or PAD are discarded and not counted.

Output:
- First-word-fall-through: tvalid = FIFO not empty, or state PAD.
- tdata and tlast stay stable while tvalid && !tready.
- A beat transfers when tvalid && tready.
- beat_cnt increments on each transfer.
- tlast = (beat_cnt == max(transfer_len,1)-1), or (state DRAIN and FIFO holds exactly 1 entry), or state PAD.
- beat_cnt returns to 0 after a tlast beat.
- transfer_len is sampled continuously; a change mid-transfer takes effect immediately. If beat_cnt already exceeds the new length-1, the next beat carries tlast.

FSM:
- IDLE -> RUN when en=1.
- RUN -> DRAIN when en=0.
- DRAIN: pops the remaining entries.
  - FIFO empty and beat_cnt==0 -> IDLE.
  - FIFO empty and beat_cnt!=0 -> PAD.
- PAD: presents one all-zero beat with tlast=1, then -> IDLE after the handshake.
- en=1 during DRAIN or PAD is ignored until IDLE is reached.
- The delay line keeps shifting in every state.

clear_stats:
- Zeroes dropped_count and overflow next cycle.
- If a drop occurs in the same cycle, the result is count=1, overflow=1.

Reset mid-transfer: the transfer is abandoned with no tlast; the downstream DMA is reset alongside.

Test Plan:
- Basic keep, FILTER_LATENCY=2, transfer_len=4:
  - Stimulus: 8 packets with data=i; keep_pkt=1 for each, 2 cycles later; tready=1.
  - Required: 8 beats with data 0..7, tlast on beats 3 and 7, dropped_count=0.
- Alternating keep:
  - Stimulus: keep only even-indexed packets of 0..9; transfer_len=0.
  - Required: beats 0,2,4,6,8, each with tlast=1.
- Overflow with FIFO_DEPTH=16:
  - Stimulus: tready=0; 20 kept packets.
  - Required: fill_level=16, dropped_count=4, overflow=1.
  - Then raise tready: beats 0..15 in order.
  - Then clear_stats: count=0, overflow=0.
- Drain and pad, transfer_len=8:
  - Stimulus: 3 kept packets, then en=0.
  - Required: beat 2 carries tlast.
  - Variant: 3 packets drained before en falls. Required: one extra zero beat with tlast, then busy=0.
- Backpressure stability:
  - Stimulus: toggle tready randomly.
  - Required: tdata and tlast unchanged whenever tvalid=1 and tready=0; no loss or duplication across 100 packets.
- Async reset mid-stream:
  - Stimulus: assert rst with 5 entries buffered.
  - Required: tvalid=0, fill_level=0, busy=0 immediately, without waiting for a clock edge.
